// File: rtl/one_hot_bus_arbiter.sv
// Eight-requester round-robin arbiter driving a one-hot bus multiplexer.
// Optional grant timeout compiled in with `define ARB_TIMEOUT_EN (limit = MAX_HOLD cycles).
module one_hot_bus_arbiter #(
  parameter int unsigned BUS_SIZE = 16,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            req,
  input  logic [8*BUS_SIZE-1:0] ch_data,
  output logic [7:0]            gnt,
  output logic [7:0]            sel,
  output logic [2:0]            owner,
  output logic                  busy,
  output logic [BUS_SIZE-1:0]   bus_out,
  output logic                  timeout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must lie in 2..255");
  end

  logic [0:0]          state, state_nxt;
  logic [2:0]          ptr, ptr_nxt;
  logic [2:0]          owner_nxt;
  logic [7:0]          gnt_nxt;
  logic                busy_nxt;
  logic [BUS_SIZE-1:0] bus_nxt;
  logic                win_found;
  logic [2:0]          win_idx;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = 8;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              timeout_nxt;
`else
  assign timeout = 1'b0;
`endif

  assign sel = gnt;

  // Rotating-priority search: first set request at or above ptr, wrapping 7->0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    for (int i = 0; i < 8; i++) begin
      if (!win_found && req[ptr + 3'(i)]) begin
        win_found = 1'b1;
        win_idx   = ptr + 3'(i);
      end
    end
  end

  // One-hot bus multiplexer; an empty grant yields all-zero data.
  always_comb begin
    bus_nxt = '0;
    for (int i = 0; i < 8; i++) begin
      if (gnt[i]) begin
        bus_nxt = bus_nxt | ch_data[BUS_SIZE*i +: BUS_SIZE];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    gnt_nxt   = gnt;
    busy_nxt  = busy;
`ifdef ARB_TIMEOUT_EN
    hold_nxt    = hold_cnt;
    timeout_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        gnt_nxt  = '0;
        busy_nxt = 1'b0;
        if (win_found) begin
          state_nxt = GRANT;
          gnt_nxt   = 8'b1 << win_idx;
          owner_nxt = win_idx;
          busy_nxt  = 1'b1;
          ptr_nxt   = win_idx + 3'd1;
`ifdef ARB_TIMEOUT_EN
          hold_nxt  = HOLD_W'(1);
`endif
        end
      end
      GRANT: begin
        if (!req[owner]) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
`ifdef ARB_TIMEOUT_EN
          hold_nxt  = '0;
        end else if (hold_cnt >= HOLD_W'(MAX_HOLD)) begin
          // Owner still requesting after the limit: force release.
          state_nxt   = IDLE;
          gnt_nxt     = '0;
          busy_nxt    = 1'b0;
          hold_nxt    = '0;
          timeout_nxt = 1'b1;
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt      <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      bus_out  <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= '0;
      timeout  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gnt      <= gnt_nxt;
      owner    <= owner_nxt;
      busy     <= busy_nxt;
      bus_out  <= bus_nxt;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= hold_nxt;
      timeout  <= timeout_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_one_hot_bus_arbiter.sv
// Scoreboard bench for one_hot_bus_arbiter: directed stimulus queues expected grants,
// a negedge monitor pops them as each new grant appears.
module tb_one_hot_bus_arbiter;

  localparam int unsigned BS = 16;

  logic            clk;
  logic            rst;
  logic [7:0]      req;
  logic [8*BS-1:0] ch_data;
  logic [7:0]      gnt;
  logic [7:0]      sel;
  logic [2:0]      owner;
  logic            busy;
  logic [BS-1:0]   bus_out;
  logic            timeout;

  one_hot_bus_arbiter #(.BUS_SIZE(BS), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .ch_data(ch_data),
    .gnt(gnt), .sel(sel), .owner(owner), .busy(busy),
    .bus_out(bus_out), .timeout(timeout)
  );

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] owner;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  logic [7:0] prev_gnt = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input int idx);
    exp_t e;
    e.gnt   = 8'b1 << idx;
    e.owner = 3'(idx);
    sb_q.push_back(e);
  endtask

  // Monitor: per-cycle invariants plus scoreboard pop on each new grant.
  always @(negedge clk) begin
    exp_t e;
    check("onehot", 32'($countones(gnt) <= 1), 32'd1);
    check("sel_eq_gnt", 32'(sel), 32'(gnt));
    check("busy_eq_any_gnt", 32'(busy), 32'(gnt != 8'h00));
    if (gnt != 8'h00 && gnt != prev_gnt) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: got gnt=%h owner=%0d, none expected", gnt, owner);
      end else begin
        e = sb_q.pop_front();
        check("grant_gnt", 32'(gnt), 32'(e.gnt));
        check("grant_owner", 32'(owner), 32'(e.owner));
      end
    end
    prev_gnt = gnt;
  end

  initial begin
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < 8; i++) ch_data[BS*i +: BS] = 16'(16'h1100 * i + 16'h0011);
    ch_data[BS*2 +: BS] = 16'h4600;

    // Reset state, then idle with no requests
    repeat (2) tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_bus_out", 32'(bus_out), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("idle_gnt", 32'(gnt), 32'h0);
      check("idle_busy", 32'(busy), 32'h0);
      check("idle_bus_out", 32'(bus_out), 32'h0);
    end

    // req=24 from ptr 0 -> owner 2, bus_out one cycle later
    expect_grant(2);
    req = 8'h24;
    tick();
    check("t2_gnt", 32'(gnt), 32'h04);
    check("t2_owner", 32'(owner), 32'd2);
    check("t2_bus_lag", 32'(bus_out), 32'h0);
    tick();
    check("t2_bus_out", 32'(bus_out), 32'h4600);
    req = 8'h00;
    tick();
    check("t2_release", 32'(gnt), 32'h0);
    tick();
    check("t2_bus_clear", 32'(bus_out), 32'h0);

    // Full rotation with all requests, each owner releasing after one cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      expect_grant(k % 8);
      req = 8'hFF;
      tick();
      check("rot_gnt", 32'(gnt), 32'(8'b1 << (k % 8)));
      req = ~(8'b1 << (k % 8));
      tick();
      check("rot_dead", 32'(gnt), 32'h0);
    end
    req = 8'h00;
    tick();

    // Wrap-around after owner 7, then hold while others request
    expect_grant(7);
    req = 8'h80;
    tick();
    check("wrap_gnt7", 32'(gnt), 32'h80);
    req = 8'h01;
    tick();
    check("wrap_dead", 32'(gnt), 32'h0);
    expect_grant(0);
    req = 8'h81;
    tick();
    check("wrap_gnt0", 32'(gnt), 32'h01);
    req = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("hold_gnt", 32'(gnt), 32'h01);
    end
    req = 8'hFE;
    tick();
    check("hold_release", 32'(gnt), 32'h0);
    expect_grant(1);
    tick();
    check("next_gnt1", 32'(gnt), 32'h02);
    req = 8'h00;
    repeat (2) tick();

    // Long grant: forced revoke with timeout, or unlimited hold
    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef ARB_TIMEOUT_EN
    expect_grant(0);
    expect_grant(1);
    req = 8'h03;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("to_hold_gnt", 32'(gnt), 32'h01);
      check("to_hold_pulse", 32'(timeout), 32'h0);
    end
    tick();
    check("to_revoke_gnt", 32'(gnt), 32'h0);
    check("to_pulse", 32'(timeout), 32'h1);
    tick();
    check("to_next_gnt", 32'(gnt), 32'h02);
    check("to_pulse_end", 32'(timeout), 32'h0);
    req = 8'h00;
    tick();
    check("to_release", 32'(gnt), 32'h0);
    check("to_no_pulse", 32'(timeout), 32'h0);
`else
    expect_grant(0);
    req = 8'h03;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("long_hold_gnt", 32'(gnt), 32'h01);
      check("long_no_timeout", 32'(timeout), 32'h0);
    end
    req = 8'h00;
    tick();
    check("long_release", 32'(gnt), 32'h0);
`endif
    tick();

    // Reset mid-grant with owner 5, then arbitrate from ptr 0
    expect_grant(5);
    req = 8'h20;
    tick();
    check("mr_gnt5", 32'(gnt), 32'h20);
    check("mr_owner5", 32'(owner), 32'd5);
    tick();
    rst = 1'b1;
    tick();
    check("mr_revoke", 32'(gnt), 32'h0);
    check("mr_busy", 32'(busy), 32'h0);
    check("mr_timeout", 32'(timeout), 32'h0);
    check("mr_bus_out", 32'(bus_out), 32'h0);
    rst = 1'b0;
    expect_grant(5);
    req = 8'h60;
    tick();
    check("mr_ptr0_gnt", 32'(gnt), 32'h20);
    req = 8'h00;
    repeat (3) tick();

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
